mem_scheduler: RTL

- Shares the core's single memory port between three requesters: data access (dmem), instruction fetch (imem) and an external debug/DMA master (xmem).
- Sits between the fetch/execute memory interfaces and the top-level memory_* port, on the same valid/ready protocol.
- Grants one transaction at a time and registers the granted request onto the memory port.
- Routes the response back to the winning requester.

---
 rtl/mem_scheduler.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/mem_scheduler.sv
// Arbiter sharing one memory port between data access, instruction fetch and a debug/DMA master.
// Define ARB_AGING_EN to add age counters that promote a starved imem/xmem requester above dmem.
module mem_scheduler #(
    parameter int AGE_LIMIT = 8,
    parameter int AGE_W     = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        imem_valid,
    input  logic [31:0] imem_addr,
    output logic        imem_ready,
    input  logic        dmem_valid,
    input  logic [31:0] dmem_addr,
    input  logic [31:0] dmem_wdata,
    input  logic [3:0]  dmem_wstrb,
    output logic        dmem_ready,
    input  logic        xmem_valid,
    input  logic [31:0] xmem_addr,
    input  logic [31:0] xmem_wdata,
    input  logic [3:0]  xmem_wstrb,
    output logic        xmem_ready,
    output logic [31:0] resp_rdata,
    output logic        memory_valid,
    output logic        memory_instr,
    output logic [31:0] memory_addr,
    output logic [31:0] memory_wdata,
    output logic [3:0]  memory_wstrb,
    input  logic [31:0] memory_rdata,
    input  logic        memory_ready
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    typedef enum logic [1:0] {
        REQ_NONE = 2'd0,
        REQ_D    = 2'd1,
        REQ_I    = 2'd2,
        REQ_X    = 2'd3
    } req_t;

    state_t      state_q, state_d;
    req_t        grant_q, grant_d;
    req_t        winner;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic        instr_q, instr_d;
    logic        done;

`ifdef ARB_AGING_EN
    localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(AGE_LIMIT);

    logic [AGE_W-1:0] age_i_q, age_i_d;
    logic [AGE_W-1:0] age_x_q, age_x_d;
    logic             promo_i, promo_x;

    assign promo_i = imem_valid && (age_i_q == AGE_MAX);
    assign promo_x = xmem_valid && (age_x_q == AGE_MAX);

    always_comb begin
        winner = REQ_NONE;
        if (promo_i)         winner = REQ_I;
        else if (promo_x)    winner = REQ_X;
        else if (dmem_valid) winner = REQ_D;
        else if (imem_valid) winner = REQ_I;
        else if (xmem_valid) winner = REQ_X;
    end

    // Any IDLE cycle with a valid requester is a grant cycle, so "valid and not winner" means it lost.
    always_comb begin
        age_i_d = age_i_q;
        age_x_d = age_x_q;
        if (!imem_valid) begin
            age_i_d = '0;
        end else if (state_q == IDLE) begin
            if (winner == REQ_I)       age_i_d = '0;
            else if (age_i_q != AGE_MAX) age_i_d = age_i_q + 1'b1;
        end
        if (!xmem_valid) begin
            age_x_d = '0;
        end else if (state_q == IDLE) begin
            if (winner == REQ_X)       age_x_d = '0;
            else if (age_x_q != AGE_MAX) age_x_d = age_x_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            age_i_q <= '0;
            age_x_q <= '0;
        end else begin
            age_i_q <= age_i_d;
            age_x_q <= age_x_d;
        end
    end
`else
    always_comb begin
        winner = REQ_NONE;
        if (dmem_valid)      winner = REQ_D;
        else if (imem_valid) winner = REQ_I;
        else if (xmem_valid) winner = REQ_X;
    end
`endif

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wstrb_d = wstrb_q;
        instr_d = instr_q;
        case (state_q)
            IDLE: begin
                if (winner != REQ_NONE) begin
                    state_d = BUSY;
                    grant_d = winner;
                    case (winner)
                        REQ_D: begin
                            addr_d  = dmem_addr;
                            wdata_d = dmem_wdata;
                            wstrb_d = dmem_wstrb;
                            instr_d = 1'b0;
                        end
                        REQ_I: begin
                            addr_d  = imem_addr;
                            wdata_d = '0;
                            wstrb_d = '0;
                            instr_d = 1'b1;
                        end
                        REQ_X: begin
                            addr_d  = xmem_addr;
                            wdata_d = xmem_wdata;
                            wstrb_d = xmem_wstrb;
                            instr_d = 1'b0;
                        end
                        default: ;
                    endcase
                end
            end
            BUSY: begin
                if (memory_ready) begin
                    state_d = IDLE;
                    grant_d = REQ_NONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            grant_q <= REQ_NONE;
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
            instr_q <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wstrb_q <= wstrb_d;
            instr_q <= instr_d;
        end
    end

    // Gated by rst so a transaction being dropped by reset never completes.
    assign done = rst && (state_q == BUSY) && memory_ready;

    assign dmem_ready   = done && (grant_q == REQ_D);
    assign imem_ready   = done && (grant_q == REQ_I);
    assign xmem_ready   = done && (grant_q == REQ_X);
    assign resp_rdata   = memory_rdata;
    assign memory_valid = (state_q == BUSY);
    assign memory_instr = instr_q;
    assign memory_addr  = addr_q;
    assign memory_wdata = wdata_q;
    assign memory_wstrb = wstrb_q;

endmodule
